// File: rtl/jtag_pkg.sv
// Shared TAP state encoding and instruction opcodes.
package jtag_pkg;

  // TAP states, using the recommended 1149.1 encoding so the LEDs match the standard.
  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SELDR   = 4'h7,
    CAPDR   = 4'h6,
    SHDR    = 4'h2,
    EX1DR   = 4'h1,
    PAUSEDR = 4'h3,
    EX2DR   = 4'h0,
    UPDR    = 4'h5,
    SELIR   = 4'h4,
    CAPIR   = 4'hE,
    SHIR    = 4'hA,
    EX1IR   = 4'h9,
    PAUSEIR = 4'hB,
    EX2IR   = 4'h8,
    UPIR    = 4'hD
  } tap_state_t;

  localparam logic [3:0] IDCODE_OP = 4'b0001;
  localparam logic [3:0] USER_OP   = 4'b0010;
  localparam logic [3:0] BYPASS_OP = 4'b1111;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller stepped by single-cycle tck pulses.
//
// state   | meaning
// TLR     | test-logic-reset, IR forced to IDCODE
// RTI     | run-test/idle
// SELDR   | select DR scan
// CAPDR   | capture selected DR
// SHDR    | shift selected DR
// EX1DR   | exit1 DR
// PAUSEDR | pause DR
// EX2DR   | exit2 DR
// UPDR    | update DR
// SELIR   | select IR scan
// CAPIR   | capture IR pattern
// SHIR    | shift IR
// EX1IR   | exit1 IR
// PAUSEIR | pause IR
// EX2IR   | exit2 IR
// UPIR    | update IR
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tck_pulse,
  input  logic       tms,
  output tap_state_t tap_state
);

  tap_state_t state_q;
  tap_state_t state_d;

  // State register; only a tck pulse moves the controller.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= TLR;
    end else if (tck_pulse) begin
      state_q <= state_d;
    end
  end

  // Standard TAP graph keyed by tms.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:     state_d = tms ? TLR   : RTI;
      RTI:     state_d = tms ? SELDR : RTI;
      SELDR:   state_d = tms ? SELIR : CAPDR;
      CAPDR:   state_d = tms ? EX1DR : SHDR;
      SHDR:    state_d = tms ? EX1DR : SHDR;
      EX1DR:   state_d = tms ? UPDR  : PAUSEDR;
      PAUSEDR: state_d = tms ? EX2DR : PAUSEDR;
      EX2DR:   state_d = tms ? UPDR  : SHDR;
      UPDR:    state_d = tms ? SELDR : RTI;
      SELIR:   state_d = tms ? TLR   : CAPIR;
      CAPIR:   state_d = tms ? EX1IR : SHIR;
      SHIR:    state_d = tms ? EX1IR : SHIR;
      EX1IR:   state_d = tms ? UPIR  : PAUSEIR;
      PAUSEIR: state_d = tms ? EX2IR : PAUSEIR;
      EX2IR:   state_d = tms ? UPIR  : SHIR;
      UPIR:    state_d = tms ? SELDR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_stepper.sv
// Button-stepped TAP with IR, IDCODE, USER and BYPASS data registers.
module jtag_tap_stepper
  import jtag_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          USER_W     = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tck_pulse,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic [3:0]        tap_state,
  output logic [IR_W-1:0]   ir_reg,
  output logic [USER_W-1:0] user_reg,
  output logic              update_strobe
);

  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(IDCODE_OP);
  localparam logic [IR_W-1:0] IR_USER   = IR_W'(USER_OP);

  tap_state_t        ps;
  logic [IR_W-1:0]   ir_shift;
  logic [31:0]       idcode_shift;
  logic [USER_W-1:0] user_shift;
  logic              bypass;

  tap_fsm u_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .tck_pulse (tck_pulse),
    .tms       (tms),
    .tap_state (ps)
  );

  assign tap_state = ps;

  // Shift/capture/update actions, decided on the state before the pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_reg        <= IR_IDCODE;
      ir_shift      <= '0;
      idcode_shift  <= '0;
      user_shift    <= '0;
      bypass        <= 1'b0;
      user_reg      <= '0;
      update_strobe <= 1'b0;
    end else begin
      update_strobe <= 1'b0;
      if (tck_pulse) begin
        // IR also resets on the edge that enters TLR so the display shows
        // IDCODE as soon as the controller arrives there.
        if (ps == TLR || (ps == SELIR && tms)) begin
          ir_reg <= IR_IDCODE;
        end
        case (ps)
          CAPIR: ir_shift <= IR_W'(1);
          SHIR:  ir_shift <= {tdi, ir_shift[IR_W-1:1]};
          EX1IR, EX2IR: begin
            if (tms) ir_reg <= ir_shift;
          end
          CAPDR: begin
            if (ir_reg == IR_IDCODE)    idcode_shift <= IDCODE_VAL;
            else if (ir_reg == IR_USER) user_shift   <= user_reg;
            else                        bypass       <= 1'b0;
          end
          SHDR: begin
            if (ir_reg == IR_IDCODE)    idcode_shift <= {tdi, idcode_shift[31:1]};
            else if (ir_reg == IR_USER) user_shift   <= {tdi, user_shift[USER_W-1:1]};
            else                        bypass       <= tdi;
          end
          EX1DR, EX2DR: begin
            if (tms && ir_reg == IR_USER) begin
              user_reg      <= user_shift;
              update_strobe <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // TDO shows the LSB of whichever register is shifting, otherwise 0.
  always_comb begin
    tdo = 1'b0;
    if (ps == SHIR) begin
      tdo = ir_shift[0];
    end else if (ps == SHDR) begin
      if (ir_reg == IR_IDCODE)    tdo = idcode_shift[0];
      else if (ir_reg == IR_USER) tdo = user_shift[0];
      else                        tdo = bypass;
    end
  end

endmodule
